instruction_fetch: RTL and testbench

Fetch stage that owns the program counter, drives the 64-bit `Address` of the read-only instruction memory, and samples its 32-bit `Data` after a fixed settle time. It presents each captured instruction and its PC to decode over a valid/ready handshake, and accepts PC redirects from the execute/branch logic for taken CBZ/B. It sits directly upstream of instruction memory and directly downstream of reset and the branch-resolution path.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_next_pc.sv | 32 +++
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_BRANCH_PREDICT_EN (in fetch_next_pc) consumes OPC_B.
package fetch_pkg;

    localparam int          PC_W        = 64;
    localparam int          INSTR_BYTES = 4;
    localparam logic [5:0]  OPC_B       = 6'b000101;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC computation for fetch: PC+4, or the static B target when
// FETCH_BRANCH_PREDICT_EN is defined.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     data_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] seq_pc;
    assign seq_pc = pc_i + PC_W'(INSTR_BYTES);

`ifdef FETCH_BRANCH_PREDICT_EN
    logic [PC_W-1:0] b_off;

    // imm26 is a word offset: sign-extend, then scale to bytes
    assign b_off = {{(PC_W-28){data_i[25]}}, data_i[25:0], 2'b00};

    always_comb begin
        next_pc_o = seq_pc;
        if (data_i[31:26] == OPC_B) begin
            next_pc_o = pc_i + b_off;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^data_i;
    assign next_pc_o   = seq_pc;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, waits WAIT_CYCLES for memory, hands instructions to
// decode over valid/ready. Optional static B prediction via FETCH_BRANCH_PREDICT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 64'h0,
    parameter logic [PC_W-1:0] END_PC      = 64'h064,
    parameter int unsigned     WAIT_CYCLES = 1
) (
    input  logic            CLK,
    input  logic            Reset,
    output logic [PC_W-1:0] Address,
    input  logic [31:0]     Data,
    output logic [31:0]     Instr,
    output logic [PC_W-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            InstrReady,
    input  logic            Redirect,
    input  logic [PC_W-1:0] RedirectPC,
    output logic            Halted
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("instruction_fetch: WAIT_CYCLES must be 1..15");
    end

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    fetch_state_e    state_q;
    logic [3:0]      cnt_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] instr_pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;
    logic            halted_q;
    logic [PC_W-1:0] next_pc_d;

    fetch_next_pc u_next_pc (
        .pc_i      (pc_q),
        .data_i    (Data),
        .next_pc_o (next_pc_d)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else if (Redirect) begin
            // a taken branch beats everything, including a same-cycle handshake
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            pc_q     <= RedirectPC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (pc_q == END_PC) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        instr_q    <= Data;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= next_pc_d;
                        state_q    <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (InstrReady) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign Address    = pc_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = valid_q;
    assign Halted     = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected (PC, Instr) pairs are queued as
// stimulus is issued and popped on each decode handshake.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DUT with WAIT_CYCLES=1
    logic        Reset = 1'b1;
    logic [63:0] Address;
    logic [31:0] Data;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic        Redirect   = 1'b0;
    logic [63:0] RedirectPC = '0;
    logic        Halted;

    // DUT with WAIT_CYCLES=3
    logic        Reset3 = 1'b1;
    logic [63:0] Address3;
    logic [31:0] Data3;
    logic [31:0] Instr3;
    logic [63:0] InstrPC3;
    logic        InstrValid3;
    logic        Halted3;

    logic [31:0] mem [25];
    exp_t        exp_q [$];
    int          hs_cyc [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    instruction_fetch #(.RESET_PC(64'h0), .END_PC(64'h064), .WAIT_CYCLES(1)) dut (
        .CLK(CLK), .Reset(Reset), .Address(Address), .Data(Data), .Instr(Instr),
        .InstrPC(InstrPC), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Halted(Halted)
    );

    instruction_fetch #(.RESET_PC(64'h0), .END_PC(64'h064), .WAIT_CYCLES(3)) dut3 (
        .CLK(CLK), .Reset(Reset3), .Address(Address3), .Data(Data3), .Instr(Instr3),
        .InstrPC(InstrPC3), .InstrValid(InstrValid3), .InstrReady(1'b0),
        .Redirect(1'b0), .RedirectPC(64'h0), .Halted(Halted3)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'h064 && a[1:0] == 2'b00) return mem[a[6:2]];
        return 32'h0;
    endfunction

    assign Data  = mem_word(Address);
    assign Data3 = mem_word(Address3);

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic push_range(input logic [63:0] first, input logic [63:0] last);
        for (logic [63:0] p = first; p <= last; p += 64'd4) push_exp(p);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_redirect(input logic [63:0] tgt);
        Redirect   = 1'b1;
        RedirectPC = tgt;
        InstrReady = 1'b1;
        @(posedge CLK); #1;
        Redirect   = 1'b0;
        InstrReady = 1'b0;
        chk("rd_valid", 64'(InstrValid), 64'd0);
        chk("rd_addr", Address, tgt);
        chk("rd_halted", 64'(Halted), 64'd0);
        @(posedge CLK); #1;
        chk("rd_lat_valid", 64'(InstrValid), 64'd1);
        chk("rd_lat_pc", InstrPC, tgt);
    endtask

    // Handshake monitor: a handshake happens at the next edge if these hold now
    always @(negedge CLK) begin
        if (!Reset && !Redirect && InstrValid && InstrReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_hs_pc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hs_instr", 64'(Instr), 64'(e.instr));
                chk("hs_pc", InstrPC, e.pc);
                hs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 25; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0]  = 32'hF840_03E9;
        mem[1]  = 32'hF840_83EA;
        mem[10] = 32'h17FF_FFFD;

        // reset values
        @(posedge CLK); #1;
        chk("rst_addr", Address, 64'h0);
        chk("rst_instr", 64'(Instr), 64'h0);
        chk("rst_ipc", InstrPC, 64'h0);
        chk("rst_valid", 64'(InstrValid), 64'd0);
        chk("rst_halted", 64'(Halted), 64'd0);
        Reset = 1'b0;

        // first capture one edge after reset, then stall decode for 5 cycles
        @(posedge CLK); #1;
        chk("first_valid", 64'(InstrValid), 64'd1);
        chk("first_instr", 64'(Instr), 64'hF84003E9);
        chk("first_pc", InstrPC, 64'h0);
        chk("first_addr", Address, 64'h4);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("stall_valid", 64'(InstrValid), 64'd1);
            chk("stall_instr", 64'(Instr), 64'hF84003E9);
            chk("stall_pc", InstrPC, 64'h0);
            chk("stall_addr", Address, 64'h4);
        end
        hs_cyc.delete();
        push_range(64'h0, 64'h8);
        InstrReady = 1'b1;
        drain(20);
        InstrReady = 1'b0;
        chk("throughput", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);

        // straight-line to 0x28, then the B at 0x28
        push_range(64'hC, 64'h28);
`ifdef FETCH_BRANCH_PREDICT_EN
        push_exp(64'h1C);
`else
        push_exp(64'h2C);
`endif
        InstrReady = 1'b1;
        drain(60);
        InstrReady = 1'b0;

        // redirect during HOLD with ready high: pending instruction is dropped
        repeat (2) begin @(posedge CLK); #1; end
        chk("hold_before_rd", 64'(InstrValid), 64'd1);
        do_redirect(64'h1C);
        push_exp(64'h1C);
        InstrReady = 1'b1;
        drain(10);
        InstrReady = 1'b0;

        // run past the B to the end of the program and halt
        repeat (2) begin @(posedge CLK); #1; end
        do_redirect(64'h2C);
        push_range(64'h2C, 64'h60);
        InstrReady = 1'b1;
        drain(80);
        begin
            int n = 0;
            while (!Halted && n < 20) begin @(posedge CLK); #1; n++; end
        end
        chk("halted", 64'(Halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("halt_valid", 64'(InstrValid), 64'd0);
            chk("halt_addr", Address, 64'h064);
        end
        chk("halt_still", 64'(Halted), 64'd1);
        do_redirect(64'h0);
        push_exp(64'h0);
        InstrReady = 1'b1;
        drain(10);
        InstrReady = 1'b0;

        // WAIT_CYCLES=3: latency, then async reset mid-HOLD
        Reset3 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK); #1;
            chk("w3_lat_valid", 64'(InstrValid3), (e == 3) ? 64'd1 : 64'd0);
        end
        chk("w3_pc", InstrPC3, 64'h0);
        chk("w3_instr", 64'(Instr3), 64'hF84003E9);
        repeat (2) begin @(posedge CLK); #1; end
        @(negedge CLK); #2;
        Reset3 = 1'b1;
        #1;
        chk("w3_arst_addr", Address3, 64'h0);
        chk("w3_arst_instr", 64'(Instr3), 64'h0);
        chk("w3_arst_ipc", InstrPC3, 64'h0);
        chk("w3_arst_valid", 64'(InstrValid3), 64'd0);
        chk("w3_arst_halted", 64'(Halted3), 64'd0);
        @(posedge CLK); #1;
        Reset3 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK); #1;
            chk("w3_relat_valid", 64'(InstrValid3), (e == 3) ? 64'd1 : 64'd0);
        end
        chk("w3_re_pc", InstrPC3, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
